multicycle_sequencer: RTL

- Multi-cycle instruction sequencer for the MINISYS CPU.
- Consumes the decoded control flags from the main decoder and steps each instruction through FETCH, DECODE, EXEC, MEM/IO and WB.
- Generates the register-enable strobes for the IR, PC, register file, data memory and I/O bus.
- Owns the I/O request/acknowledge handshake with a timeout, and gates execution for program-load mode.

---
 rtl/multicycle_sequencer_if.sv | 31 +++
 rtl/multicycle_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer_if.sv
// Bundle of decoder flags, datapath strobes and I/O handshake between the
// MINISYS sequencer (master) and the datapath/decoder side (slave).
interface multicycle_sequencer_if;
  logic        run;
  logic [4:0]  dec_flow;
  logic [3:0]  dec_mem;
  logic        RegWrite;
  logic        io_ack;
  logic        ir_en;
  logic        pc_en;
  logic        reg_we;
  logic        mem_re;
  logic        mem_we;
  logic        io_rd_req;
  logic        io_wr_req;
  logic        io_err;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  modport master (
    input  run, dec_flow, dec_mem, RegWrite, io_ack,
    output ir_en, pc_en, reg_we, mem_re, mem_we, io_rd_req, io_wr_req,
           io_err, state, instr_cnt
  );

  modport slave (
    output run, dec_flow, dec_mem, RegWrite, io_ack,
    input  ir_en, pc_en, reg_we, mem_re, mem_we, io_rd_req, io_wr_req,
           io_err, state, instr_cnt
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer for MINISYS: FETCH/DECODE/EXEC/MEM/IOWAIT/WB
// with datapath strobes, I/O request timeout and program-load parking.
module multicycle_sequencer #(
  parameter int FETCH_WAIT = 1,
  parameter int MEM_WAIT   = 1,
  parameter int IO_TIMEOUT = 255
) (
  input logic clock,
  input logic reset_n,
  multicycle_sequencer_if.master bus
);
  // state  | meaning
  // FETCH  | instruction-memory read; parks here while run=0
  // DECODE | decoder settles
  // EXEC   | sample decoder flags, resolve next state
  // MEM    | data-memory access
  // IOWAIT | I/O request outstanding until ack or timeout
  // WB     | register write-back and PC commit
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_IOWAIT = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam int WAIT_MAX = (FETCH_WAIT > MEM_WAIT) ? FETCH_WAIT : MEM_WAIT;
  localparam int WAIT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  state_t              state_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [15:0]         to_cnt;
  logic                kind_wr;
  logic                io_err_q;
  logic [31:0]         instr_cnt_q;
  logic                pc_en;

  logic jr, jmp, jal, br, nbr, mem_rd, mem_wr, io_rd, io_wr;
  logic flow_jump, mem_any, io_any;
  logic fetch_last, mem_last, io_exit;

  assign {jr, jmp, jal, br, nbr}       = bus.dec_flow;
  assign {mem_rd, mem_wr, io_rd, io_wr} = bus.dec_mem;
  assign flow_jump  = jr | jmp | br | nbr;
  assign mem_any    = mem_rd | mem_wr;
  assign io_any     = io_rd | io_wr;
  assign fetch_last = (wait_cnt == WAIT_W'(FETCH_WAIT));
  assign mem_last   = (wait_cnt == WAIT_W'(MEM_WAIT));
  // Ack wins over a coincident timeout, so io_err is only set when ack is absent.
  assign io_exit    = bus.io_ack | (to_cnt == 16'(IO_TIMEOUT - 1));

  always_comb begin
    pc_en = 1'b0;
    case (state_q)
      S_EXEC:   pc_en = ~jal & (flow_jump | ~(mem_any | io_any | bus.RegWrite));
      S_MEM:    pc_en = kind_wr & mem_last;
      S_IOWAIT: pc_en = kind_wr & io_exit;
      S_WB:     pc_en = 1'b1;
      default:  pc_en = 1'b0;
    endcase
  end

  assign bus.pc_en     = pc_en;
  assign bus.ir_en     = (state_q == S_FETCH) & bus.run & fetch_last;
  assign bus.reg_we    = (state_q == S_WB);
  assign bus.mem_re    = (state_q == S_MEM) & ~kind_wr;
  assign bus.mem_we    = (state_q == S_MEM) & kind_wr & mem_last;
  assign bus.io_rd_req = (state_q == S_IOWAIT) & ~kind_wr;
  assign bus.io_wr_req = (state_q == S_IOWAIT) & kind_wr;
  assign bus.io_err    = io_err_q;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      wait_cnt    <= '0;
      to_cnt      <= '0;
      kind_wr     <= 1'b0;
      io_err_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_q + 32'(pc_en);
      case (state_q)
        S_FETCH: begin
          if (bus.run) begin
            if (fetch_last) begin
              state_q  <= S_DECODE;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (jal) begin
            state_q <= S_WB;
          end else if (flow_jump) begin
            state_q <= S_FETCH;
          end else if (mem_any) begin
            state_q <= S_MEM;
            kind_wr <= ~mem_rd;
          end else if (io_any) begin
            state_q <= S_IOWAIT;
            kind_wr <= ~io_rd;
            to_cnt  <= '0;
          end else if (bus.RegWrite) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_last) begin
            state_q  <= kind_wr ? S_FETCH : S_WB;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_IOWAIT: begin
          if (io_exit) begin
            state_q <= kind_wr ? S_FETCH : S_WB;
            if (!bus.io_ack) io_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_WB: state_q <= S_FETCH;
        default: begin
          state_q  <= S_FETCH;
          wait_cnt <= '0;
        end
      endcase
    end
  end
endmodule
